// File: rtl/snes_pkg.sv
// Shared types, default timing and sizing helpers for the SNES/NES poll master.
package snes_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StGap,
    StClkLo,
    StClkHi,
    StDone
  } state_e;

  localparam int unsigned DefLatchPeriodCyc = 800000;
  localparam int unsigned DefLatchWidthCyc  = 576;
  localparam int unsigned DefHalfClkCyc     = 288;
  localparam int unsigned DefNumBits        = 16;

  localparam int unsigned DefPeriodW = $clog2(DefLatchPeriodCyc);
  localparam int unsigned DefWidthW  = $clog2(DefLatchWidthCyc);
  localparam int unsigned DefHalfW   = $clog2(DefHalfClkCyc);
  localparam int unsigned DefBitsW   = $clog2(DefNumBits);

  // Bits needed for a counter running 0 .. n-1 (never narrower than 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned poll_len(input int unsigned width_cyc,
                                           input int unsigned half_cyc,
                                           input int unsigned num_bits);
    return width_cyc + half_cyc * (1 + 2 * num_bits);
  endfunction

endpackage

// File: rtl/snes_poll_capture.sv
// One controller data line: 2FF synchroniser, sample shift register and committed capture word.
module snes_poll_capture #(
  parameter int unsigned NUM_BITS = 16
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                d_i,
  input  logic                sample_i,
  input  logic                commit_i,
  output logic [NUM_BITS-1:0] cap_o
);

  logic [1:0]          sync_q;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] cap_q;

  // Right shift so the first sample of a poll ends up in bit 0 after NUM_BITS samples.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      shift_q <= '0;
      cap_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
      if (sample_i) begin
        shift_q <= {sync_q[1], shift_q[NUM_BITS-1:1]};
      end
      if (commit_i) begin
        cap_q <= shift_q;
      end
    end
  end

  assign cap_o = cap_q;

endmodule

// File: rtl/snes_poll_master.sv
// Console-side SNES/NES poller: latch and serial clock generation, optional data capture.
// Capture path is built only when SNES_POLL_CAPTURE_EN is defined.
module snes_poll_master
  import snes_pkg::*;
#(
  parameter int unsigned LATCH_PERIOD_CYC = DefLatchPeriodCyc,
  parameter int unsigned LATCH_WIDTH_CYC  = DefLatchWidthCyc,
  parameter int unsigned HALF_CLK_CYC     = DefHalfClkCyc,
  parameter int unsigned NUM_BITS         = DefNumBits,
  parameter int unsigned NUM_CH           = 3
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       free_run,
  input  logic                       start,
  input  logic [NUM_CH-1:0]          d_in,
  output logic                       snes_lat,
  output logic                       snes_clk,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH*NUM_BITS-1:0] cap_data,
  output logic                       cap_valid,
  output logic [7:0]                 overrun
);

  localparam int unsigned PhaseMax = (LATCH_WIDTH_CYC > HALF_CLK_CYC) ? LATCH_WIDTH_CYC
                                                                       : HALF_CLK_CYC;
  localparam int unsigned TmrW = cnt_w(LATCH_PERIOD_CYC);
  localparam int unsigned PhW  = cnt_w(PhaseMax);
  localparam int unsigned BitW = cnt_w(NUM_BITS);

  localparam logic [TmrW-1:0] TmrLast   = TmrW'(LATCH_PERIOD_CYC - 1);
  localparam logic [PhW-1:0]  LatchLast = PhW'(LATCH_WIDTH_CYC - 1);
  localparam logic [PhW-1:0]  HalfLast  = PhW'(HALF_CLK_CYC - 1);
  localparam logic [BitW-1:0] BitLast   = BitW'(NUM_BITS - 1);

  if (LATCH_PERIOD_CYC <= poll_len(LATCH_WIDTH_CYC, HALF_CLK_CYC, NUM_BITS)) begin : g_bad_period
    $error("LATCH_PERIOD_CYC must exceed the poll length");
  end
  if (HALF_CLK_CYC < 4) begin : g_bad_half
    $error("HALF_CLK_CYC must be at least 4");
  end

  state_e          state_q;
  logic [TmrW-1:0] tmr_q;
  logic [PhW-1:0]  ph_q;
  logic [BitW-1:0] bit_q;
  logic            free_run_q;
  logic            lat_q;
  logic            sclk_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      ovr_q;
  logic            trigger;

  assign trigger = enable & (free_run ? (tmr_q == TmrLast) : start);

  // Period timer: held at 0 while disabled, restarted whenever the trigger mode changes.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tmr_q      <= '0;
      free_run_q <= 1'b0;
    end else begin
      free_run_q <= free_run;
      if (!enable || (free_run != free_run_q) || (tmr_q == TmrLast)) begin
        tmr_q <= '0;
      end else begin
        tmr_q <= tmr_q + TmrW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ph_q    <= '0;
      bit_q   <= '0;
      lat_q   <= 1'b0;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (trigger && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (trigger) begin
            lat_q   <= 1'b1;
            busy_q  <= 1'b1;
            ph_q    <= '0;
            state_q <= StLatch;
          end
        end
        StLatch: begin
          if (ph_q == LatchLast) begin
            lat_q   <= 1'b0;
            ph_q    <= '0;
            state_q <= StGap;
          end else begin
            ph_q <= ph_q + PhW'(1);
          end
        end
        StGap: begin
          if (ph_q == HalfLast) begin
            sclk_q  <= 1'b0;
            ph_q    <= '0;
            bit_q   <= '0;
            state_q <= StClkLo;
          end else begin
            ph_q <= ph_q + PhW'(1);
          end
        end
        StClkLo: begin
          if (ph_q == HalfLast) begin
            sclk_q  <= 1'b1;
            ph_q    <= '0;
            state_q <= StClkHi;
          end else begin
            ph_q <= ph_q + PhW'(1);
          end
        end
        StClkHi: begin
          if (ph_q == HalfLast) begin
            ph_q <= '0;
            if (bit_q == BitLast) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              bit_q   <= bit_q + BitW'(1);
              sclk_q  <= 1'b0;
              state_q <= StClkLo;
            end
          end else begin
            ph_q <= ph_q + PhW'(1);
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign snes_lat = lat_q;
  assign snes_clk = sclk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = ovr_q;

`ifdef SNES_POLL_CAPTURE_EN
  logic sample;
  logic commit;
  logic cap_valid_q;

  // The final pulse's high phase carries no new bit; its end commits the word instead.
  assign sample = ((state_q == StGap) && (ph_q == HalfLast)) ||
                  ((state_q == StClkHi) && (ph_q == HalfLast) && (bit_q != BitLast));
  assign commit = (state_q == StClkHi) && (ph_q == HalfLast) && (bit_q == BitLast);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    snes_poll_capture #(
      .NUM_BITS(NUM_BITS)
    ) u_cap (
      .sys_clk (sys_clk),
      .rst     (rst),
      .d_i     (d_in[c]),
      .sample_i(sample),
      .commit_i(commit),
      .cap_o   (cap_data[c*NUM_BITS +: NUM_BITS])
    );
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cap_valid_q <= 1'b0;
    end else if (commit) begin
      cap_valid_q <= 1'b1;
    end
  end

  assign cap_valid = cap_valid_q;
`else
  logic unused_d_in;

  assign unused_d_in = ^d_in;
  assign cap_data    = '0;
  assign cap_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_snes_poll_master.sv
// Directed bench for snes_poll_master with a behavioural controller model on the data lines.
`timescale 1ns/1ps
module tb_snes_poll_master;

  localparam int unsigned NB = 16;
  localparam int unsigned NC = 3;

`ifdef SNES_POLL_CAPTURE_EN
  localparam logic [NC*NB-1:0] ExpCap1  = {16'h0000, 16'hFFFF, 16'hAAAA};
  localparam logic [NC*NB-1:0] ExpCap2  = {16'h5A5A, 16'h8001, 16'h1234};
  localparam logic             ExpValid = 1'b1;
`else
  localparam logic [NC*NB-1:0] ExpCap1  = '0;
  localparam logic [NC*NB-1:0] ExpCap2  = '0;
  localparam logic             ExpValid = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              free_run;
  logic              start;
  logic [NC-1:0]     d_in;
  logic              snes_lat;
  logic              snes_clk;
  logic              busy;
  logic              done;
  logic [NC*NB-1:0]  cap_data;
  logic              cap_valid;
  logic [7:0]        overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_rises = 0;
  int r0;

  logic [NB-1:0] words  [NC];
  logic [NB-1:0] ctl_sh [NC];
  logic          prev_clk;
  logic          prev_lat;

  always #5 sys_clk = ~sys_clk;

  snes_poll_master #(
    .LATCH_PERIOD_CYC(200),
    .LATCH_WIDTH_CYC (4),
    .HALF_CLK_CYC    (4),
    .NUM_BITS        (NB),
    .NUM_CH          (NC)
  ) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .enable   (enable),
    .free_run (free_run),
    .start    (start),
    .d_in     (d_in),
    .snes_lat (snes_lat),
    .snes_clk (snes_clk),
    .busy     (busy),
    .done     (done),
    .cap_data (cap_data),
    .cap_valid(cap_valid),
    .overrun  (overrun)
  );

  // Controller: parallel load while latched, shift on each serial clock rising edge.
  always @(posedge sys_clk) begin
    prev_clk <= snes_clk;
    prev_lat <= snes_lat;
    if (snes_lat && !prev_lat) lat_rises <= lat_rises + 1;
    for (int c = 0; c < NC; c++) begin
      if (snes_lat) ctl_sh[c] <= words[c];
      else if (snes_clk && !prev_clk) ctl_sh[c] <= {1'b1, ctl_sh[c][NB-1:1]};
    end
  end

  assign d_in = {ctl_sh[2][0], ctl_sh[1][0], ctl_sh[0][0]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_lat(input string tag, input int bound);
    int i = 0;
    while (snes_lat !== 1'b1 && i < bound) begin
      @(negedge sys_clk);
      i++;
    end
    check(tag, 64'(snes_lat), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i = 0;
    while (done !== 1'b1 && i < bound) begin
      @(negedge sys_clk);
      i++;
    end
    check(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; free_run = 1'b1; start = 1'b0;
    words[0] = 16'hAAAA; words[1] = 16'hFFFF; words[2] = 16'h0000;
    tick(3);
    check("rst_lat",       64'(snes_lat),  64'd0);
    check("rst_clk",       64'(snes_clk),  64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_cap",       64'(cap_data),  64'd0);
    check("rst_valid",     64'(cap_valid), 64'd0);
    check("rst_overrun",   64'(overrun),   64'd0);

    // Free-running poll timing, offsets relative to the latch rising edge.
    rst = 1'b0; enable = 1'b1;
    wait_lat("fr_first_latch", 400);
    tick(3);   check("fr_lat_hold",  64'(snes_lat), 64'd1);
    tick(1);   check("fr_lat_fall",  64'(snes_lat), 64'd0);
               check("fr_gap_clk",   64'(snes_clk), 64'd1);
    tick(4);   check("fr_clk_lo",    64'(snes_clk), 64'd0);
    tick(4);   check("fr_clk_hi",    64'(snes_clk), 64'd1);
    tick(123); check("fr_pre_done",  64'(done),     64'd0);
               check("fr_busy",      64'(busy),     64'd1);
    tick(1);   check("fr_done",      64'(done),     64'd1);
               check("fr_cap",       64'(cap_data), 64'(ExpCap1));
               check("fr_valid",     64'(cap_valid), 64'(ExpValid));
    tick(1);   check("fr_done_1cyc", 64'(done),     64'd0);
               check("fr_busy_off",  64'(busy),     64'd0);
    tick(62);  check("fr_pre_period", 64'(snes_lat), 64'd0);
    tick(1);   check("fr_period",    64'(snes_lat), 64'd1);

    // Switch to start mode during the second poll; the timer must no longer fire.
    tick(10);  free_run = 1'b0;
    wait_done("sm_poll2_done", 200);
    tick(2);
    r0 = lat_rises;
    tick(250);
    check("sm_no_timer_poll", 64'(lat_rises - r0), 64'd0);
    check("sm_overrun0",      64'(overrun),        64'd0);

    // Start pulse, then a second start 10 cycles later while busy.
    r0 = lat_rises;
    start = 1'b1; tick(1); start = 1'b0;
    check("sm_start_latch", 64'(snes_lat), 64'd1);
    tick(9); start = 1'b1; tick(1); start = 1'b0;
    check("sm_overrun1", 64'(overrun), 64'd1);
    tick(126); check("sm_done", 64'(done), 64'd1);
    tick(20);
    check("sm_single_poll", 64'(lat_rises - r0), 64'd1);
    check("sm_cap",         64'(cap_data),       64'(ExpCap1));

    // Five requests while busy, then a long burst that must saturate.
    start = 1'b1; tick(1);
    check("ov_trigger", 64'(snes_lat), 64'd1);
    tick(5); start = 1'b0;
    check("ov_count6", 64'(overrun), 64'd6);
    start = 1'b1; tick(300); start = 1'b0;
    check("ov_sat", 64'(overrun), 64'd255);
    wait_done("ov_drain", 200);
    tick(2);
    check("ov_idle", 64'(busy), 64'd0);

    // Drop enable mid-poll: the poll completes, then nothing starts.
    start = 1'b1; tick(1); start = 1'b0;
    check("en_latch", 64'(snes_lat), 64'd1);
    tick(50); enable = 1'b0;
    tick(86); check("en_done", 64'(done), 64'd1);
    tick(1);  check("en_busy_off", 64'(busy), 64'd0);
    free_run = 1'b1;
    r0 = lat_rises;
    tick(500); start = 1'b1; tick(1); start = 1'b0; tick(499);
    check("en_no_latch", 64'(lat_rises - r0), 64'd0);
    check("en_idle",     64'(busy),           64'd0);

    // Asynchronous reset mid-poll, then a clean poll with new controller words.
    words[0] = 16'h1234; words[1] = 16'h8001; words[2] = 16'h5A5A;
    enable = 1'b1;
    wait_lat("ar_latch", 400);
    tick(70);
    check("ar_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("ar_lat",     64'(snes_lat),  64'd0);
    check("ar_clk",     64'(snes_clk),  64'd1);
    check("ar_busy",    64'(busy),      64'd0);
    check("ar_cap",     64'(cap_data),  64'd0);
    check("ar_valid",   64'(cap_valid), 64'd0);
    check("ar_overrun", 64'(overrun),   64'd0);
    tick(2); rst = 1'b0;
    wait_lat("ar_relatch", 400);
    tick(136);
    check("ar_done",    64'(done),      64'd1);
    check("ar_cap2",    64'(cap_data),  64'(ExpCap2));
    check("ar_valid2",  64'(cap_valid), 64'(ExpValid));
    check("ar_overrun2", 64'(overrun),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
